// File: rtl/memory_array_pkg.sv
// -----------------------------------------------------------------------------
// memory_array_pkg
//   Shared definitions for the memory_array block:
//     - mem_state_e : request FSM state encodings (IDLE=0, ACCESS=1, RESP=2)
//     - even_parity : even-parity helper used when MEM_PARITY_EN is defined
// -----------------------------------------------------------------------------
package memory_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mem_state_e;

    // Even parity over a zero-extended vector; zero padding does not change
    // the XOR reduction, so callers cast narrower data up to 64 bits.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage : memory_array_pkg

// File: rtl/memory_word.sv
// -----------------------------------------------------------------------------
// memory_word
//   One storage row of the memory array. Loads d on a rising clock edge while
//   we is high, otherwise holds. Cleared to zero by the asynchronous reset.
//   Ports:
//     clk   in  1     clock
//     rst_n in  1     asynchronous active-low reset
//     we    in  1     write enable
//     d     in  W     row write data
//     q     out W     stored row
// -----------------------------------------------------------------------------
module memory_word #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] row_d;
    logic [W-1:0] row_q;

    // Next-row selection: load on write enable, hold otherwise.
    always_comb begin
        row_d = row_q;
        if (we) begin
            row_d = d;
        end else begin
            row_d = row_q;
        end
    end

    // Row storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign q = row_q;

endmodule : memory_word

// File: rtl/memory_array.sv
// -----------------------------------------------------------------------------
// memory_array
//   DEPTH x WIDTH synchronous storage array behind a four-phase sel/ack
//   request port. A request accepted in IDLE is executed in ACCESS one cycle
//   later and answered in RESP, where ack stays high until sel drops.
//   Read data is presented on a tristate bus that is only driven in RESP of
//   a read.
//
//   Optional feature macro: MEM_PARITY_EN
//     defined   : one even-parity bit per word, extra input perr_inj inverts
//                 the stored parity on write; a read with bad parity sets err.
//     undefined : no parity storage, no perr_inj port; err = out-of-range only.
//
//   Ports:
//     clk      in  1       clock
//     rst_n    in  1       asynchronous active-low reset
//     sel      in  1       request, held until ack seen
//     rw       in  1       1 = write, 0 = read (sampled with sel)
//     addr     in  ADDR_W  word address (sampled with sel)
//     in       in  WIDTH   write data (sampled with sel)
//     perr_inj in  1       parity corruption on write (MEM_PARITY_EN only)
//     out      out WIDTH   read data, tristate
//     ack      out 1       request complete, held until sel low
//     busy     out 1       state != IDLE
//     err      out 1       out-of-range address or parity fault, valid with ack
// -----------------------------------------------------------------------------
module memory_array
    import memory_array_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  in,
`ifdef MEM_PARITY_EN
    input  logic              perr_inj,
`endif
    output wire  [WIDTH-1:0]  out,
    output logic              ack,
    output logic              busy,
    output logic              err
);

`ifdef MEM_PARITY_EN
    localparam int ROW_W = WIDTH + 1;
`else
    localparam int ROW_W = WIDTH;
`endif

    // Request FSM and latched request fields
    mem_state_e        state_d, state_q;
    logic              rw_d, rw_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [WIDTH-1:0]  wdata_d, wdata_q;
`ifdef MEM_PARITY_EN
    logic              pinj_d, pinj_q;
`endif

    // Response registers
    logic [WIDTH-1:0]  rdata_d, rdata_q;
    logic              ack_d, ack_q;
    logic              err_d, err_q;
    logic              busy_d, busy_q;
    logic              drive_d, drive_q;

    // Array interface
    logic [DEPTH-1:0]  row_we_s;
    logic [ROW_W-1:0]  row_wdata_s;
    logic [ROW_W-1:0]  row_q_s [DEPTH];
    logic [ROW_W-1:0]  row_sel_s;
    logic              in_range_s;

    // Compare against DEPTH with one spare bit so a power-of-two DEPTH does
    // not wrap to zero.
    assign in_range_s = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));

`ifdef MEM_PARITY_EN
    assign row_wdata_s = {even_parity(64'(wdata_q)) ^ pinj_q, wdata_q};
`else
    assign row_wdata_s = wdata_q;
`endif

    // Write decode: exactly one row enabled in ACCESS of an in-range write.
    always_comb begin
        row_we_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((state_q == ST_ACCESS) && rw_q && (addr_q == ADDR_W'(i))) begin
                row_we_s[i] = 1'b1;
            end else begin
                row_we_s[i] = 1'b0;
            end
        end
    end

    // Read mux: compare-select so unused address codes return zero.
    always_comb begin
        row_sel_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                row_sel_s = row_q_s[i];
            end else begin
                row_sel_s = row_sel_s;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_row
            memory_word #(
                .W (ROW_W)
            ) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (row_we_s[g]),
                .d     (row_wdata_s),
                .q     (row_q_s[g])
            );
        end
    endgenerate

    // FSM next state, request capture and response generation.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef MEM_PARITY_EN
        pinj_d  = pinj_q;
`endif
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (sel) begin
                    state_d = ST_ACCESS;
                    rw_d    = rw;
                    addr_d  = addr;
                    wdata_d = in;
`ifdef MEM_PARITY_EN
                    pinj_d  = perr_inj;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Runs regardless of sel; the request was already committed.
                state_d = ST_RESP;
                ack_d   = 1'b1;
                if (rw_q) begin
                    err_d = !in_range_s;
                end else if (in_range_s) begin
                    rdata_d = row_sel_s[WIDTH-1:0];
`ifdef MEM_PARITY_EN
                    err_d   = (even_parity(64'(row_sel_s[WIDTH-1:0])) != row_sel_s[WIDTH]);
`else
                    err_d   = 1'b0;
`endif
                end else begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            ST_RESP: begin
                if (sel) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
                err_d   = 1'b0;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        drive_d = (state_d == ST_RESP) && !rw_d;
    end

    // State, request and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_PARITY_EN
            pinj_q  <= 1'b0;
`endif
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MEM_PARITY_EN
            pinj_q  <= pinj_d;
`endif
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            drive_q <= drive_d;
        end
    end

    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign out  = drive_q ? rdata_q : {WIDTH{1'bz}};

endmodule : memory_array

// File: tb/tb_memory_array.sv
// -----------------------------------------------------------------------------
// tb_memory_array
//   Directed plus random transactions on a 6 x 8 memory_array, checked against
//   an array model of the memory. The out bus is pulled up, so a released bus
//   reads as all ones.
// -----------------------------------------------------------------------------
module tb_memory_array;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 6;
    localparam int ADDR_W = 3;
    localparam logic [WIDTH-1:0] REL = 8'hFF;   // value of the released bus
`ifdef MEM_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sel = 1'b0;
    logic              rw = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [WIDTH-1:0]  in_d = '0;
`ifdef MEM_PARITY_EN
    logic              perr_inj = 1'b0;
`endif
    wire  [WIDTH-1:0]  out_w;
    logic              ack, busy, err;

    int checks = 0;
    int failures = 0;

    // Reference model
    logic [WIDTH-1:0] mem [DEPTH];
    bit               bad [DEPTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_pu
        pullup (out_w[i]);
    end

    memory_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .rw       (rw),
        .addr     (addr),
        .in       (in_d),
`ifdef MEM_PARITY_EN
        .perr_inj (perr_inj),
`endif
        .out      (out_w),
        .ack      (ack),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            bad[i] = 1'b0;
        end
    endtask

    // One full four-phase transaction; hold = extra cycles sel stays high in RESP.
    task automatic txn(input bit w, input int a, input logic [WIDTH-1:0] d,
                       input bit inj, input int hold);
        logic [WIDTH-1:0] exp_out;
        bit               exp_err;
        bit               in_rng;
        in_rng = (a < DEPTH);
        if (w) begin
            exp_out = REL;
            exp_err = !in_rng;
            if (in_rng) begin
                mem[a] = d;
                bad[a] = PAR_ON && inj;
            end
        end else begin
            exp_out = in_rng ? mem[a] : '0;
            exp_err = !in_rng || bad[a];
        end
        @(negedge clk);
        sel  = 1'b1;
        rw   = w;
        addr = ADDR_W'(a);
        in_d = d;
`ifdef MEM_PARITY_EN
        perr_inj = inj;
`endif
        @(posedge clk); #1;
        chk("access_busy", 32'(busy), 32'd1);
        chk("access_ack", 32'(ack), 32'd0);
        // Inputs changed after acceptance must not affect this transaction.
        rw   = ~w;
        addr = ADDR_W'($urandom_range(0, 7));
        in_d = WIDTH'($urandom);
        @(posedge clk); #1;
        chk("resp_ack", 32'(ack), 32'd1);
        chk("resp_err", 32'(err), 32'(exp_err));
        chk("resp_out", 32'(out_w), 32'(exp_out));
        for (int h = 0; h < hold; h++) begin
            in_d = WIDTH'($urandom);
            rw   = 1'b1;
            @(posedge clk); #1;
            chk("hold_ack", 32'(ack), 32'd1);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        sel = 1'b0;
        @(posedge clk); #1;
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_err", 32'(err), 32'd0);
        chk("idle_out", 32'(out_w), 32'(REL));
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(out_w), 32'(REL));
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Every word reads zero after reset
        for (int a = 0; a < DEPTH; a++) txn(1'b0, a, 8'h00, 1'b0, 0);

        // Basic write then read
        txn(1'b1, 3, 8'hA5, 1'b0, 0);
        txn(1'b0, 3, 8'h00, 1'b0, 0);

        // Out-of-range write leaves array intact; out-of-range read gives 0
        txn(1'b1, 6, 8'hFF, 1'b0, 0);
        for (int a = 0; a < DEPTH; a++) txn(1'b0, a, 8'h00, 1'b0, 0);
        txn(1'b0, 7, 8'h00, 1'b0, 0);

        // sel held high in RESP: no second write, in changes ignored
        txn(1'b1, 4, 8'h5A, 1'b0, 5);
        txn(1'b0, 4, 8'h00, 1'b0, 2);

        // Reset asserted during ACCESS of a write
        @(negedge clk);
        sel = 1'b1; rw = 1'b1; addr = 3'd1; in_d = 8'h3C;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        sel   = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out", 32'(out_w), 32'(REL));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 1, 8'h00, 1'b0, 0);
        txn(1'b0, 3, 8'h00, 1'b0, 0);

`ifdef MEM_PARITY_EN
        // Parity injection and recovery
        txn(1'b1, 2, 8'h0F, 1'b1, 0);
        txn(1'b0, 2, 8'h00, 1'b0, 0);
        txn(1'b1, 2, 8'h0F, 1'b0, 0);
        txn(1'b0, 2, 8'h00, 1'b0, 0);
`endif

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                WIDTH'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)));
        end
        for (int a = 0; a < DEPTH; a++) txn(1'b0, a, 8'h00, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_memory_array
